vga_timing_gen: RTL and testbench

Pixel-clock timing generator that sits directly upstream of the VGA output register stage.
- Runs horizontal and vertical counters.
- Emits pixel coordinates and a pixel-request strobe to the pixel source (frame buffer or pattern logic).
- Emits HSYNC, VSYNC, BLANK_N and SYNC_N, delayed by a configurable number of cycles so they arrive aligned with the source's RGB data.
- Both the RGB data and these timing signals feed the output register stage.

---
 rtl/vga_timing_pkg.sv | 33 +++
 rtl/vga_delay_line.sv | 43 ++++
 rtl/vga_timing_gen.sv | 133 +++++++++++++
 tb/tb_vga_timing_gen.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, polarity encodings and width helpers.
package vga_timing_pkg;

    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;
    localparam int unsigned VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int unsigned VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam logic POL_ACTIVE_LOW  = 1'b0;
    localparam logic POL_ACTIVE_HIGH = 1'b1;

    // Smallest width w with 2^w >= value.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((33'd1 << i) < {1'b0, value}) width = i + 1;
        end
        return width;
    endfunction

    // Counter width that can hold every value up to the larger total.
    function automatic int unsigned cnt_width(input int unsigned h_total, input int unsigned v_total);
        return clog2(((h_total > v_total) ? h_total : v_total) + 1);
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with a parameterised reset value; depth 0 is a wire.
module vga_delay_line #(
    parameter int unsigned       WIDTH   = 3,
    parameter int unsigned       DEPTH   = 2,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH == 0) begin : g_wire
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;
        assign dout = din;
    end else begin : g_pipe
        logic [WIDTH-1:0] pipe_q [DEPTH];
        logic [WIDTH-1:0] pipe_d [DEPTH];

        // Next tap values: new sample enters tap 0, everything else moves one deeper.
        always_comb begin
            pipe_d[0] = din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
        end

        // Tap registers; reset loads the idle pattern into every tap.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    pipe_q[i] <= RST_VAL;
                end
            end else begin
                pipe_q <= pipe_d;
            end
        end

        assign dout = pipe_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster counters, stage-0 pixel request/coordinates, and latency-matched sync/blank.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE     = VGA_H_ACTIVE,
    parameter int unsigned H_FP         = VGA_H_FP,
    parameter int unsigned H_SYNC       = VGA_H_SYNC,
    parameter int unsigned H_BP         = VGA_H_BP,
    parameter int unsigned V_ACTIVE     = VGA_V_ACTIVE,
    parameter int unsigned V_FP         = VGA_V_FP,
    parameter int unsigned V_SYNC       = VGA_V_SYNC,
    parameter int unsigned V_BP         = VGA_V_BP,
    parameter logic        HS_POL       = POL_ACTIVE_LOW,
    parameter logic        VS_POL       = POL_ACTIVE_LOW,
    parameter int unsigned DATA_LATENCY = 2,
    parameter int unsigned CW           = cnt_width(H_ACTIVE + H_FP + H_SYNC + H_BP,
                                                    V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic          iPIXEL_CLK,
    input  logic          iRST_N,
    input  logic          iENABLE,
    output logic [CW-1:0] oX,
    output logic [CW-1:0] oY,
    output logic          oREQ,
    output logic          oLINE_START,
    output logic          oFRAME_START,
    output logic          oHSYNC,
    output logic          oVSYNC,
    output logic          oBLANK_N,
    output logic          oSYNC_N
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [2:0]    TIMING_IDLE = {~HS_POL, ~VS_POL, 1'b0};

    logic [CW-1:0] h_cnt_q, h_cnt_d;
    logic [CW-1:0] v_cnt_q, v_cnt_d;
    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic          req_q, req_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          hs_act, vs_act, in_active;
    logic [2:0]    timing_dly;

    // Raster counter advance; disable parks both counters on the last position so
    // the first enabled edge always lands on (0,0).
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (!iENABLE) begin
            h_cnt_d = H_LAST;
            v_cnt_d = V_LAST;
        end else if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CW'(1);
        end else begin
            h_cnt_d = h_cnt_q + CW'(1);
        end
    end

    // Stage-0 decode from the next counter values so outputs align with the counters.
    always_comb begin
        in_active     = (h_cnt_d < CW'(H_ACTIVE)) && (v_cnt_d < CW'(V_ACTIVE));
        hs_act        = (h_cnt_d >= CW'(HS_START)) && (h_cnt_d < CW'(HS_END));
        vs_act        = (v_cnt_d >= CW'(VS_START)) && (v_cnt_d < CW'(VS_END));
        x_d           = iENABLE ? h_cnt_d : '0;
        y_d           = iENABLE ? v_cnt_d : '0;
        req_d         = iENABLE && in_active;
        line_start_d  = iENABLE && (h_cnt_d == '0);
        frame_start_d = line_start_d && (v_cnt_d == '0);
        hsync_d       = (iENABLE && hs_act) ? HS_POL : ~HS_POL;
        vsync_d       = (iENABLE && vs_act) ? VS_POL : ~VS_POL;
    end

    // Counter and stage-0 output registers.
    always_ff @(posedge iPIXEL_CLK or negedge iRST_N) begin
        if (!iRST_N) begin
            h_cnt_q       <= H_LAST;
            v_cnt_q       <= V_LAST;
            x_q           <= '0;
            y_q           <= '0;
            req_q         <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            x_q           <= x_d;
            y_q           <= y_d;
            req_q         <= req_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
        end
    end

    // Delay sync/blank to line up with the pixel source's RGB.
    vga_delay_line #(
        .WIDTH   (3),
        .DEPTH   (DATA_LATENCY),
        .RST_VAL (TIMING_IDLE)
    ) u_timing_dly (
        .clk   (iPIXEL_CLK),
        .rst_n (iRST_N),
        .din   ({hsync_q, vsync_q, req_q}),
        .dout  (timing_dly)
    );

    assign oX           = x_q;
    assign oY           = y_q;
    assign oREQ         = req_q;
    assign oLINE_START  = line_start_q;
    assign oFRAME_START = frame_start_q;
    assign oHSYNC       = timing_dly[2];
    assign oVSYNC       = timing_dly[1];
    assign oBLANK_N     = timing_dly[0];
    assign oSYNC_N      = 1'b1;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three builds (default, small raster, zero latency) checked
// every cycle against a position-from-enabled-edge-count model, plus spot tables.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    localparam int NDUT = 3;

    typedef struct {
        int   ha, hf, hs, va, vf, vs, ht, vt, lat;
        logic hpol, vpol;
    } geo_t;

    typedef struct {
        logic [31:0] x, y;
        logic        req, ls, fs, hs, vs, bl, sn;
    } obs_t;

    typedef struct {
        int   n;
        logic en;
        int   x, y;
        logic req, fs, hs, bl;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b0;

    always #5 clk = ~clk;

    logic [9:0] a_x, a_y;
    logic       a_req, a_ls, a_fs, a_hs, a_vs, a_bl, a_sn;
    logic [3:0] s_x, s_y;
    logic       s_req, s_ls, s_fs, s_hs, s_vs, s_bl, s_sn;
    logic [9:0] z_x, z_y;
    logic       z_req, z_ls, z_fs, z_hs, z_vs, z_bl, z_sn;

    vga_timing_gen dut_a (
        .iPIXEL_CLK(clk), .iRST_N(rst_n), .iENABLE(en),
        .oX(a_x), .oY(a_y), .oREQ(a_req), .oLINE_START(a_ls), .oFRAME_START(a_fs),
        .oHSYNC(a_hs), .oVSYNC(a_vs), .oBLANK_N(a_bl), .oSYNC_N(a_sn)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .HS_POL(POL_ACTIVE_LOW), .VS_POL(POL_ACTIVE_HIGH), .DATA_LATENCY(3), .CW(4)
    ) dut_s (
        .iPIXEL_CLK(clk), .iRST_N(rst_n), .iENABLE(en),
        .oX(s_x), .oY(s_y), .oREQ(s_req), .oLINE_START(s_ls), .oFRAME_START(s_fs),
        .oHSYNC(s_hs), .oVSYNC(s_vs), .oBLANK_N(s_bl), .oSYNC_N(s_sn)
    );

    vga_timing_gen #(
        .HS_POL(POL_ACTIVE_HIGH), .DATA_LATENCY(0)
    ) dut_z (
        .iPIXEL_CLK(clk), .iRST_N(rst_n), .iENABLE(en),
        .oX(z_x), .oY(z_y), .oREQ(z_req), .oLINE_START(z_ls), .oFRAME_START(z_fs),
        .oHSYNC(z_hs), .oVSYNC(z_vs), .oBLANK_N(z_bl), .oSYNC_N(z_sn)
    );

    geo_t        G [NDUT];
    obs_t        obs [NDUT];
    obs_t        expv [NDUT];
    int unsigned run [NDUT];
    logic [2:0]  hist [NDUT][16];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int win   = 0;
    int s_fs_cnt, s_ls_cnt, s_req_cnt, s_vs_cnt, s_fs1, s_fs2;
    int z_hs_cnt, z_bad;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endfunction

    function automatic void sample();
        obs[0].x = 32'(a_x); obs[0].y = 32'(a_y); obs[0].req = a_req; obs[0].ls = a_ls;
        obs[0].fs = a_fs; obs[0].hs = a_hs; obs[0].vs = a_vs; obs[0].bl = a_bl; obs[0].sn = a_sn;
        obs[1].x = 32'(s_x); obs[1].y = 32'(s_y); obs[1].req = s_req; obs[1].ls = s_ls;
        obs[1].fs = s_fs; obs[1].hs = s_hs; obs[1].vs = s_vs; obs[1].bl = s_bl; obs[1].sn = s_sn;
        obs[2].x = 32'(z_x); obs[2].y = 32'(z_y); obs[2].req = z_req; obs[2].ls = z_ls;
        obs[2].fs = z_fs; obs[2].hs = z_hs; obs[2].vs = z_vs; obs[2].bl = z_bl; obs[2].sn = z_sn;
    endfunction

    // Expected outputs: stage 0 from the raster position, delayed fields from history.
    function automatic void make_exp(int i, int h, int v, logic act, logic ls, logic fs);
        logic [2:0] d;
        d = hist[i][G[i].lat];
        expv[i].x   = 32'(h);
        expv[i].y   = 32'(v);
        expv[i].req = act;
        expv[i].ls  = ls;
        expv[i].fs  = fs;
        expv[i].hs  = d[2] ? G[i].hpol : ~G[i].hpol;
        expv[i].vs  = d[1] ? G[i].vpol : ~G[i].vpol;
        expv[i].bl  = d[0];
        expv[i].sn  = 1'b1;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NDUT; i++) begin
            run[i] = 0;
            for (int k = 0; k < 16; k++) hist[i][k] = 3'b000;
            make_exp(i, 0, 0, 1'b0, 1'b0, 1'b0);
        end
    endfunction

    // One clock edge: position is (enabled edges since last stop - 1) modulo frame size.
    function automatic void model_edge();
        int unsigned p, h, v;
        logic act, hsa, vsa, ls, fs;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int i = 0; i < NDUT; i++) begin
            run[i] = en ? run[i] + 1 : 0;
            h = 0; v = 0; act = 0; hsa = 0; vsa = 0; ls = 0; fs = 0;
            if (run[i] != 0) begin
                p   = (run[i] - 1) % (G[i].ht * G[i].vt);
                h   = p % G[i].ht;
                v   = p / G[i].ht;
                act = (h < G[i].ha) && (v < G[i].va);
                hsa = (h >= G[i].ha + G[i].hf) && (h < G[i].ha + G[i].hf + G[i].hs);
                vsa = (v >= G[i].va + G[i].vf) && (v < G[i].va + G[i].vf + G[i].vs);
                ls  = (h == 0);
                fs  = (p == 0);
            end
            for (int k = 15; k > 0; k--) hist[i][k] = hist[i][k-1];
            hist[i][0] = {hsa, vsa, act};
            make_exp(i, int'(h), int'(v), act, ls, fs);
        end
    endfunction

    function automatic void check_all();
        sample();
        for (int i = 0; i < NDUT; i++) begin
            chk($sformatf("d%0d.x", i),       obs[i].x,   expv[i].x);
            chk($sformatf("d%0d.y", i),       obs[i].y,   expv[i].y);
            chk($sformatf("d%0d.req", i),     obs[i].req, expv[i].req);
            chk($sformatf("d%0d.line_st", i), obs[i].ls,  expv[i].ls);
            chk($sformatf("d%0d.frame_st", i),obs[i].fs,  expv[i].fs);
            chk($sformatf("d%0d.hsync", i),   obs[i].hs,  expv[i].hs);
            chk($sformatf("d%0d.vsync", i),   obs[i].vs,  expv[i].vs);
            chk($sformatf("d%0d.blank_n", i), obs[i].bl,  expv[i].bl);
            chk($sformatf("d%0d.sync_n", i),  obs[i].sn,  expv[i].sn);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        win++;
        model_edge();
        check_all();
        if (obs[1].fs) begin
            s_fs_cnt++;
            if (s_fs_cnt == 1) s_fs1 = win;
            else if (s_fs_cnt == 2) s_fs2 = win;
        end
        if (obs[1].ls)  s_ls_cnt++;
        if (obs[1].req) s_req_cnt++;
        if (obs[1].vs)  s_vs_cnt++;
        if (obs[2].hs)  z_hs_cnt++;
        if (obs[2].bl !== obs[2].req) z_bad++;
    endtask

    // Assert reset between edges and check every output has already reverted.
    task automatic async_reset();
        step();
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        step();
        rst_n = 1'b1;
    endtask

    vec_t tbl [16];

    initial begin
        G[0] = '{VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC, VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC,
                 VGA_H_TOTAL, VGA_V_TOTAL, 2, 1'b0, 1'b0};
        G[1] = '{8, 2, 3, 6, 2, 2, 15, 13, 3, 1'b0, 1'b1};
        G[2] = '{640, 16, 96, 480, 10, 2, 800, 525, 0, 1'b1, 1'b0};

        // Default build, cumulative edges after reset release: {edges, en, x, y, req, fs, hsync, blank_n}
        tbl[0]  = '{1,   1'b1, 0,   0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[1]  = '{1,   1'b1, 1,   0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{1,   1'b1, 2,   0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[3]  = '{638, 1'b1, 640, 0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[4]  = '{2,   1'b1, 642, 0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{15,  1'b1, 657, 0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1,   1'b1, 658, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{95,  1'b1, 753, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1,   1'b1, 754, 0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{46,  1'b1, 0,   1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{300, 1'b1, 300, 1, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[11] = '{1,   1'b0, 0,   0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[12] = '{1,   1'b0, 0,   0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[13] = '{1,   1'b0, 0,   0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[14] = '{7,   1'b0, 0,   0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[15] = '{1,   1'b1, 0,   0, 1'b1, 1'b1, 1'b1, 1'b0};

        // Reset state, held across a couple of edges.
        model_reset();
        step();
        step();

        rst_n    = 1'b1;
        en       = 1'b1;
        z_hs_cnt = 0;
        z_bad    = 0;
        for (int r = 0; r < 16; r++) begin
            en = tbl[r].en;
            repeat (tbl[r].n) step();
            chk($sformatf("tbl%0d.x", r),       obs[0].x,   32'(tbl[r].x));
            chk($sformatf("tbl%0d.y", r),       obs[0].y,   32'(tbl[r].y));
            chk($sformatf("tbl%0d.req", r),     obs[0].req, tbl[r].req);
            chk($sformatf("tbl%0d.frame_st", r),obs[0].fs,  tbl[r].fs);
            chk($sformatf("tbl%0d.hsync", r),   obs[0].hs,  tbl[r].hs);
            chk($sformatf("tbl%0d.blank_n", r), obs[0].bl,  tbl[r].bl);
        end
        chk("zlat.hsync_high_cycles", z_hs_cnt, 96);
        chk("zlat.blank_ne_req_cycles", z_bad, 0);

        // Two full frames of the small raster from a fresh start.
        en = 1'b0;
        repeat (3) step();
        en = 1'b1;
        win = 0; s_fs_cnt = 0; s_ls_cnt = 0; s_req_cnt = 0; s_vs_cnt = 0; s_fs1 = -1; s_fs2 = -1;
        repeat (390) step();
        chk("small.frame_starts", s_fs_cnt, 2);
        chk("small.first_fs_edge", s_fs1, 1);
        chk("small.fs_spacing", s_fs2 - s_fs1, 195);
        chk("small.line_starts", s_ls_cnt, 26);
        chk("small.req_cycles", s_req_cnt, 96);
        chk("small.vsync_cycles", s_vs_cnt, 60);
        step();
        chk("small.wrap_fs", obs[1].fs, 1'b1);
        chk("small.wrap_x", obs[1].x, 0);
        chk("small.wrap_y", obs[1].y, 0);

        // Mid-line asynchronous reset, then random enable drops and resets.
        repeat (37) step();
        async_reset();
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 599) == 0) begin
                async_reset();
            end else begin
                en = ($urandom_range(0, 39) != 0);
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
